// File: rtl/pc_stack.sv
// pc_stack: program counter with conditional jump and a return-address stack.
// Latency: pc/sp/flags update on the posedge that samples the request; the bus is driven one cycle after CO.
// Backpressure: none. One action per cycle (RET > CALL > jump > CE > hold); lower-priority requests are dropped.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   bus                shared tri-state bus (drives {0,pc} while output enabled; jump/call targets come from it)
//   CE, J, JC, cond    count enable, jump, conditional jump (taken when cond=1)
//   CALL, RET          push pc and load target / pop into pc
//   CO                 counter-out request (registered output enable)
//   pc, sp             current PC and stack occupancy
//   stack_full/empty   decoded from sp
//   stack_err          sticky overflow/underflow flag, cleared only by rst
module pc_stack #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    BUS_WIDTH    = 8,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  localparam int                   SP_W         = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [BUS_WIDTH-1:0]  bus,
  input  logic                  CE,
  input  logic                  J,
  input  logic                  JC,
  input  logic                  cond,
  input  logic                  CALL,
  input  logic                  RET,
  input  logic                  CO,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [SP_W-1:0]       sp,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_err
);

  // Storage is sized to the full sp index range so sp can address it directly;
  // entries at or above STACK_DEPTH are never written.
  logic [ADDR_WIDTH-1:0] stack_mem [2**SP_W];

  logic                  out_en;
  logic [BUS_WIDTH-1:0]  bus_out;
  logic [ADDR_WIDTH-1:0] load_tgt;
  logic                  jump_taken;
  logic                  push_ok;
  logic                  unused_bus_hi;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  assign load_tgt      = bus[ADDR_WIDTH-1:0];
  // Upper bus bits carry no meaning for a load.
  assign unused_bus_hi = ^bus;

  assign jump_taken = J | (JC & cond);
  assign push_ok    = !RET && CALL && !stack_full;

  // Zero-extend the live pc onto the bus.
  always_comb begin
    bus_out                 = '0;
    bus_out[ADDR_WIDTH-1:0] = pc;
  end

  assign bus = out_en ? bus_out : {BUS_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      sp        <= '0;
      stack_err <= 1'b0;
      out_en    <= 1'b0;
    end else begin
      out_en <= CO;
      if (RET) begin
        if (!stack_empty) begin
          pc <= stack_mem[sp - SP_W'(1)];
          sp <= sp - SP_W'(1);
        end else begin
          stack_err <= 1'b1;
        end
      end else if (CALL) begin
        if (!stack_full) begin
          pc <= load_tgt;
          sp <= sp + SP_W'(1);
        end else begin
          stack_err <= 1'b1;
        end
      end else if (jump_taken) begin
        pc <= load_tgt;
      end else if (CE) begin
        pc <= pc + ADDR_WIDTH'(1);
      end
    end
  end

  // Return address is the pc held at the CALL edge (already advanced by fetch).
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stack_mem[sp] <= pc;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, CE = 1'b0, J = 1'b0, JC = 1'b0, cond = 1'b0;
  logic CALL = 1'b0, RET = 1'b0, CO = 1'b0;
  logic          tb_oe = 1'b0;
  logic [BW-1:0] tb_val = '0;
  wire  [BW-1:0] bus;
  logic [AW-1:0] pc;
  logic [SPW-1:0] sp;
  logic stack_full, stack_empty, stack_err;

  // Released bus reads all ones; the DUT never drives that (upper bits are zero).
  assign bus = tb_oe ? tb_val : {BW{1'bz}};
  for (genvar gi = 0; gi < BW; gi++) begin : g_pu
    pullup (bus[gi]);
  end

  pc_stack #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .STACK_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .CE(CE), .J(J), .JC(JC), .cond(cond),
    .CALL(CALL), .RET(RET), .CO(CO), .pc(pc), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: return addresses in a queue, pc as an integer mod 16.
  int pc_m  = 0;
  int err_m = 0;
  int oe_m  = 0;
  int stk[$];
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    int busv;
    busv = (oe_m != 0) ? pc_m : (tb_oe ? int'(tb_val) : 255);
    if (rst) begin
      pc_m = 0; err_m = 0; stk.delete();
    end else if (RET) begin
      if (stk.size() > 0) pc_m = stk.pop_back();
      else err_m = 1;
    end else if (CALL) begin
      if (stk.size() < DEPTH) begin
        stk.push_back(pc_m);
        pc_m = busv % 16;
      end else err_m = 1;
    end else if (J || (JC && cond)) begin
      pc_m = busv % 16;
    end else if (CE) begin
      pc_m = (pc_m + 1) % 16;
    end
    oe_m = (!rst && CO) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", int'(pc), pc_m);
      chk("sp", int'(sp), stk.size());
      chk("full", int'(stack_full), (stk.size() == DEPTH) ? 1 : 0);
      chk("empty", int'(stack_empty), (stk.size() == 0) ? 1 : 0);
      chk("err", int'(stack_err), err_m);
      if (!tb_oe) chk("bus", int'(bus), (oe_m != 0) ? pc_m : 255);
    end
  end

  task automatic cyc(input bit r, input bit ce, input bit j, input bit jc, input bit c,
                     input bit call, input bit ret, input bit co, input bit drv,
                     input logic [BW-1:0] v);
    #1;
    rst = r; CE = ce; J = j; JC = jc; cond = c; CALL = call; RET = ret; CO = co;
    tb_oe = drv; tb_val = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cmp_en = 1'b1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_sp", int'(sp), 0);
    chk("rst_empty", int'(stack_empty), 1);
    chk("rst_err", int'(stack_err), 0);
    chk("rst_bus", int'(bus), 8'hFF);

    // counting with wrap
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("ce_pc", int'(pc), (i + 1) % 16);
    end
    chk("ce_bus", int'(bus), 8'hFF);

    // jumps
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 8'hA7);
    chk("j_pc", int'(pc), 7);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 1, 8'h03);
    chk("ce_j_pc", int'(pc), 3);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h05);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 1, 8'h0C);
    chk("jc0_pc", int'(pc), 6);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 1, 8'h0C);
    chk("jc1_pc", int'(pc), 12);

    // nested calls
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h02);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h08);
    chk("call1_pc", int'(pc), 8);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h09);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h0A);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h0B);
    chk("call4_sp", int'(sp), 4);
    chk("call4_full", int'(stack_full), 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h05);
    chk("ovf_pc", int'(pc), 11);
    chk("ovf_err", int'(stack_err), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("ret1_pc", int'(pc), 11);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("ret2_pc", int'(pc), 10);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("ret3_pc", int'(pc), 9);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("ret4_pc", int'(pc), 2);
    chk("ret4_empty", int'(stack_empty), 1);
    chk("ret4_err", int'(stack_err), 1);

    // underflow and RET over CALL
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    chk("unf_pc", int'(pc), 0);
    chk("unf_err", int'(stack_err), 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h06);
    chk("call_pc", int'(pc), 6);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 1, 8'h09);
    chk("retcall_pc", int'(pc), 1);
    chk("retcall_sp", int'(sp), 0);
    chk("err_sticky", int'(stack_err), 1);

    // bus timing
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("co_bus", int'(bus), 8'h01);
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("co_live_bus", int'(bus), 8'h02);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("co_rel_bus", int'(bus), 8'hFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("co2_bus", int'(bus), 8'h02);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    chk("rst_drive_bus", int'(bus), 8'hFF);
    chk("rst_drive_pc", int'(pc), 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, ce, j, jc, c, call, ret, co, drv;
      r    = ($urandom_range(0, 63) == 0);
      ce   = $urandom_range(0, 1) == 1;
      j    = ($urandom_range(0, 7) == 0);
      jc   = ($urandom_range(0, 5) == 0);
      c    = $urandom_range(0, 1) == 1;
      call = ($urandom_range(0, 4) == 0);
      ret  = ($urandom_range(0, 5) == 0);
      co   = ($urandom_range(0, 3) == 0);
      drv  = (oe_m == 0) && !co && ($urandom_range(0, 3) != 0);
      cyc(r, ce, j, jc, c, call, ret, co, drv, 8'($urandom));
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
